// File: rtl/definitions.sv
// Shared types for the run sequencer: instruction opcodes, ALU operations and
// sequencer states.
package definitions;

  typedef enum logic [3:0] {
    OpAdd     = 4'h0,
    OpSub     = 4'h1,
    OpAnd     = 4'h2,
    OpOr      = 4'h3,
    OpXor     = 4'h4,
    OpShl     = 4'h5,
    OpShr     = 4'h6,
    OpAddi    = 4'h7,
    OpLd      = 4'h8,
    OpSt      = 4'h9,
    OpBrz     = 4'hA,
    OpBrnz    = 4'hB,
    OpJmp     = 4'hC,
    OpJr      = 4'hD,
    OpSetpc   = 4'hE,
    OpSpecial = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    AluAdd  = 3'd0,
    AluSub  = 3'd1,
    AluAnd  = 3'd2,
    AluOr   = 3'd3,
    AluXor  = 3'd4,
    AluShl  = 3'd5,
    AluShr  = 3'd6,
    AluPass = 3'd7
  } alu_op_t;

  // OpSpecial with this fcode is HALT; the other value is NOP.
  localparam logic HALT_FCODE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DONE_ST,
    TIMEOUT
  } seq_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/fcode decoder producing the datapath control strobes;
// every strobe is held at zero while enable_i is low.
module ctrl_decode
  import definitions::*;
(
  input  logic       enable_i,
  input  logic [3:0] opcode_i,
  input  logic       fcode_i,
  output logic       branch_rel_nz_o,
  output logic       branch_rel_z_o,
  output logic       branch_abs_o,
  output logic       reg_write_en_o,
  output logic       reg_sel_o,
  output logic       lut_in_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_o,
  output logic       alu_sc_in_o,
  output logic       read_mem_o,
  output logic       write_mem_o,
  output logic [2:0] alu_op_o
);

  alu_op_t alu_op;

  always_comb begin
    branch_rel_nz_o = 1'b0;
    branch_rel_z_o  = 1'b0;
    branch_abs_o    = 1'b0;
    reg_write_en_o  = 1'b0;
    reg_sel_o       = 1'b0;
    lut_in_o        = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_o       = 1'b0;
    alu_sc_in_o     = 1'b0;
    read_mem_o      = 1'b0;
    write_mem_o     = 1'b0;
    alu_op          = AluAdd;
    if (enable_i) begin
      unique case (opcode_t'(opcode_i))
        OpAdd:  begin alu_op = AluAdd; reg_write_en_o = 1'b1; end
        OpSub:  begin alu_op = AluSub; reg_write_en_o = 1'b1; end
        OpAnd:  begin alu_op = AluAnd; reg_write_en_o = 1'b1; end
        OpOr:   begin alu_op = AluOr;  reg_write_en_o = 1'b1; end
        OpXor:  begin alu_op = AluXor; reg_write_en_o = 1'b1; end
        OpShl:  begin alu_op = AluShl; reg_write_en_o = 1'b1; alu_sc_in_o = fcode_i; end
        OpShr:  begin alu_op = AluShr; reg_write_en_o = 1'b1; alu_sc_in_o = fcode_i; end
        OpAddi: begin alu_op = AluAdd; reg_write_en_o = 1'b1; alu_src_o = 1'b1; end
        OpLd: begin
          read_mem_o     = 1'b1;
          mem_to_reg_o   = 1'b1;
          reg_write_en_o = 1'b1;
        end
        OpSt:    write_mem_o = 1'b1;
        OpBrz:   begin branch_rel_z_o = 1'b1;  alu_op = AluSub; end
        OpBrnz:  begin branch_rel_nz_o = 1'b1; alu_op = AluSub; end
        OpJmp:   branch_abs_o = 1'b1;
        OpJr:    begin branch_abs_o = 1'b1; lut_in_o = 1'b1; end
        OpSetpc: begin reg_sel_o = 1'b1; reg_write_en_o = 1'b1; end
        // NOP and HALT both leave every strobe idle.
        OpSpecial: begin end
        default: begin end
      endcase
    end
  end

  assign alu_op_o = alu_op;

endmodule

// File: rtl/run_sequencer.sv
// Run controller: holds the datapath in init, releases it on GO, decodes each
// instruction into strobes, counts RUN cycles and detects completion/timeout.
module run_sequencer
  import definitions::*;
#(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_CYCLES  = 32'hFFFF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             GO,
  input  logic [3:0]       opcode,
  input  logic             fcode,
  input  logic             DP_DONE,
  output logic             START,
  output logic             CTRL_branch_rel_nz,
  output logic             CTRL_branch_rel_z,
  output logic             CTRL_branch_abs,
  output logic             CTRL_reg_write_en,
  output logic             CTRL_reg_sel,
  output logic             CTRL_lut_in,
  output logic             CTRL_mem_to_reg,
  output logic             CTRL_alu_src,
  output logic             CTRL_alu_sc_in,
  output logic             CTRL_read_mem,
  output logic             CTRL_write_mem,
  output logic [2:0]       CTRL_alu_op,
  output logic             BUSY,
  output logic             FINISHED,
  output logic             TIMED_OUT,
  output logic [CNT_W-1:0] CYCLES
);

  localparam int unsigned      InitW     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [InitW-1:0] LastInit  = InitW'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LastCycle = CNT_W'(MAX_CYCLES - 1);

  seq_state_t       state_q;
  logic [InitW-1:0] init_cnt_q;
  logic [CNT_W-1:0] cycles_q;
  logic             start_q, busy_q, finished_q, timed_out_q;
  logic             is_halt;

  assign is_halt = (opcode_t'(opcode) == OpSpecial) && (fcode == HALT_FCODE);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      init_cnt_q  <= '0;
      cycles_q    <= '0;
      start_q     <= 1'b1;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE_ST, TIMEOUT: begin
          if (GO) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            cycles_q    <= '0;
            start_q     <= 1'b1;
            busy_q      <= 1'b1;
            finished_q  <= 1'b0;
            timed_out_q <= 1'b0;
          end
        end
        INIT: begin
          if (init_cnt_q == LastInit) begin
            state_q <= RUN;
            start_q <= 1'b0;
          end else begin
            init_cnt_q <= init_cnt_q + InitW'(1);
          end
        end
        RUN: begin
          if (cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
          // Completion wins over the watchdog when both land on the same cycle.
          if (DP_DONE || is_halt) begin
            state_q    <= DONE_ST;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
          end else if (cycles_q == LastCycle) begin
            state_q     <= TIMEOUT;
            busy_q      <= 1'b0;
            timed_out_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ctrl_decode u_ctrl_decode (
    .enable_i        (state_q == RUN),
    .opcode_i        (opcode),
    .fcode_i         (fcode),
    .branch_rel_nz_o (CTRL_branch_rel_nz),
    .branch_rel_z_o  (CTRL_branch_rel_z),
    .branch_abs_o    (CTRL_branch_abs),
    .reg_write_en_o  (CTRL_reg_write_en),
    .reg_sel_o       (CTRL_reg_sel),
    .lut_in_o        (CTRL_lut_in),
    .mem_to_reg_o    (CTRL_mem_to_reg),
    .alu_src_o       (CTRL_alu_src),
    .alu_sc_in_o     (CTRL_alu_sc_in),
    .read_mem_o      (CTRL_read_mem),
    .write_mem_o     (CTRL_write_mem),
    .alu_op_o        (CTRL_alu_op)
  );

  assign START     = start_q;
  assign BUSY      = busy_q;
  assign FINISHED  = finished_q;
  assign TIMED_OUT = timed_out_q;
  assign CYCLES    = cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: a default instance plus a MAX_CYCLES=5 instance
// sharing the same inputs, with strobe expectations queued on a scoreboard.
module tb_run_sequencer;

  localparam int unsigned CntW = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [3:0] opcode;
  logic       fcode;
  logic       dp_done;

  always #5 clk = ~clk;

  logic            start, busy, finished, timed_out;
  logic [CntW-1:0] cycles;
  logic brnz, brz, babs, rwe, rsel, lut, m2r, asrc, scin, rd, wr;
  logic [2:0]      aluop;
  wire  [13:0]     ctrl = {brnz, brz, babs, rwe, rsel, lut, m2r, asrc, scin, rd, wr, aluop};

  logic            start5, busy5, finished5, timed_out5;
  logic [CntW-1:0] cycles5;
  logic brnz5, brz5, babs5, rwe5, rsel5, lut5, m2r5, asrc5, scin5, rd5, wr5;
  logic [2:0]      aluop5;
  wire  [13:0]     ctrl5 = {brnz5, brz5, babs5, rwe5, rsel5, lut5, m2r5, asrc5, scin5, rd5,
                            wr5, aluop5};

  run_sequencer dut (
    .CLK(clk), .reset(reset), .GO(go), .opcode(opcode), .fcode(fcode), .DP_DONE(dp_done),
    .START(start), .CTRL_branch_rel_nz(brnz), .CTRL_branch_rel_z(brz),
    .CTRL_branch_abs(babs), .CTRL_reg_write_en(rwe), .CTRL_reg_sel(rsel),
    .CTRL_lut_in(lut), .CTRL_mem_to_reg(m2r), .CTRL_alu_src(asrc), .CTRL_alu_sc_in(scin),
    .CTRL_read_mem(rd), .CTRL_write_mem(wr), .CTRL_alu_op(aluop), .BUSY(busy),
    .FINISHED(finished), .TIMED_OUT(timed_out), .CYCLES(cycles)
  );

  run_sequencer #(.MAX_CYCLES(5)) dut5 (
    .CLK(clk), .reset(reset), .GO(go), .opcode(opcode), .fcode(fcode), .DP_DONE(dp_done),
    .START(start5), .CTRL_branch_rel_nz(brnz5), .CTRL_branch_rel_z(brz5),
    .CTRL_branch_abs(babs5), .CTRL_reg_write_en(rwe5), .CTRL_reg_sel(rsel5),
    .CTRL_lut_in(lut5), .CTRL_mem_to_reg(m2r5), .CTRL_alu_src(asrc5), .CTRL_alu_sc_in(scin5),
    .CTRL_read_mem(rd5), .CTRL_write_mem(wr5), .CTRL_alu_op(aluop5), .BUSY(busy5),
    .FINISHED(finished5), .TIMED_OUT(timed_out5), .CYCLES(cycles5)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [13:0] ctrl;
  } exp_t;

  exp_t sb[$];

  // Bit layout: nz z abs rwe rsel lut m2r asrc scin rd wr alu_op[2:0]
  function automatic logic [13:0] exp_ctrl(input logic [3:0] op, input logic fc,
                                           input logic en);
    logic [13:0] r;
    r = '0;
    if (!en) return r;
    case (op)
      4'h0: r[10] = 1'b1;
      4'h1: begin r[2:0] = 3'd1; r[10] = 1'b1; end
      4'h2: begin r[2:0] = 3'd2; r[10] = 1'b1; end
      4'h3: begin r[2:0] = 3'd3; r[10] = 1'b1; end
      4'h4: begin r[2:0] = 3'd4; r[10] = 1'b1; end
      4'h5: begin r[2:0] = 3'd5; r[10] = 1'b1; r[5] = fc; end
      4'h6: begin r[2:0] = 3'd6; r[10] = 1'b1; r[5] = fc; end
      4'h7: begin r[6] = 1'b1; r[10] = 1'b1; end
      4'h8: begin r[4] = 1'b1; r[7] = 1'b1; r[10] = 1'b1; end
      4'h9: r[3] = 1'b1;
      4'hA: begin r[12] = 1'b1; r[2:0] = 3'd1; end
      4'hB: begin r[13] = 1'b1; r[2:0] = 3'd1; end
      4'hC: r[11] = 1'b1;
      4'hD: begin r[11] = 1'b1; r[8] = 1'b1; end
      4'hE: begin r[9] = 1'b1; r[10] = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [3:0] op, input logic fc,
                          input logic en);
    exp_t e;
    e.name = name;
    e.ctrl = exp_ctrl(op, fc, en);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0; opcode = 4'h0; fcode = 1'b0; dp_done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // From IDLE: one GO cycle, two INIT cycles, then the first RUN cycle begins.
  task automatic start_run();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; opcode = 4'h8; fcode = 1'b0; dp_done = 1'b0;
    #1;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL reset_start: got %b exp 1", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (finished !== 1'b0 || timed_out !== 1'b0) begin
      errors++; $display("FAIL reset_status: got %b%b exp 00", finished, timed_out);
    end
    checks++; if (cycles !== '0) begin errors++; $display("FAIL reset_cycles: got %0d exp 0", cycles); end
    checks++; if (ctrl !== '0) begin errors++; $display("FAIL reset_ctrl: got %h exp 0", ctrl); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_start_sequence();
    do_reset();
    opcode = 4'h7;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (start !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL init%0d_start_busy: got %b%b exp 11", i, start, busy);
      end
      checks++; if (ctrl !== '0) begin errors++; $display("FAIL init%0d_ctrl: got %h exp 0", i, ctrl); end
      tick();
    end
    checks++; if (start !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL run_start_busy: got %b%b exp 01", start, busy);
    end
    push_exp("run_first_addi", 4'h7, 1'b0, 1'b1);
    #1;
    begin
      exp_t e = sb.pop_front();
      checks++; if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s: got %h exp %h", e.name, ctrl, e.ctrl); end
    end
  endtask

  task automatic test_decode();
    do_reset();
    start_run();
    for (int op = 0; op < 16; op++) begin
      for (int fc = 0; fc < 2; fc++) begin
        if (!(op == 15 && fc == 1)) begin
          opcode = 4'(op); fcode = 1'(fc);
          push_exp($sformatf("decode_%h_%0d", op, fc), 4'(op), 1'(fc), 1'b1);
          #1;
          begin
            exp_t e = sb.pop_front();
            checks++; if (ctrl !== e.ctrl) begin
              errors++; $display("FAIL %s: got %h exp %h", e.name, ctrl, e.ctrl);
            end
          end
          tick();
        end
      end
    end
    checks++; if (busy !== 1'b1 || cycles !== 16'd31) begin
      errors++; $display("FAIL decode_run_count: busy %b cycles %0d exp 1 31", busy, cycles);
    end
  endtask

  task automatic test_run_to_done();
    do_reset();
    start_run();
    opcode = 4'h0; fcode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_exp($sformatf("add_cycle%0d", i), 4'h0, 1'b0, 1'b1);
      #1;
      begin
        exp_t e = sb.pop_front();
        checks++; if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s: got %h exp %h", e.name, ctrl, e.ctrl); end
      end
      tick();
    end
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    checks++; if (finished !== 1'b1 || busy !== 1'b0 || timed_out !== 1'b0) begin
      errors++; $display("FAIL done_status: got f%b b%b t%b exp f1 b0 t0", finished, busy, timed_out);
    end
    checks++; if (cycles !== 16'd11) begin errors++; $display("FAIL done_cycles: got %0d exp 11", cycles); end
    push_exp("done_ctrl_gated", 4'h0, 1'b0, 1'b0);
    #1;
    begin
      exp_t e = sb.pop_front();
      checks++; if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s: got %h exp %h", e.name, ctrl, e.ctrl); end
    end
    tick();
    checks++; if (cycles !== 16'd11 || finished !== 1'b1) begin
      errors++; $display("FAIL done_hold: cycles %0d fin %b exp 11 1", cycles, finished);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (start !== 1'b1 || cycles !== '0 || busy !== 1'b1 || finished !== 1'b0) begin
      errors++; $display("FAIL rego: start %b cycles %0d busy %b fin %b exp 1 0 1 0",
                         start, cycles, busy, finished);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = 4'hF; fcode = 1'b0;
    start_run();
    checks++; if (ctrl5 !== '0) begin errors++; $display("FAIL nop_ctrl5: got %h exp 0", ctrl5); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (busy5 !== 1'b1 || timed_out5 !== 1'b0 || cycles5 !== 16'd4) begin
      errors++; $display("FAIL pre_timeout: busy %b to %b cycles %0d exp 1 0 4", busy5, timed_out5, cycles5);
    end
    tick();
    checks++; if (timed_out5 !== 1'b1 || busy5 !== 1'b0 || finished5 !== 1'b0 || start5 !== 1'b0) begin
      errors++; $display("FAIL timeout: to %b busy %b fin %b start %b exp 1 0 0 0",
                         timed_out5, busy5, finished5, start5);
    end
    checks++; if (cycles5 !== 16'd5) begin errors++; $display("FAIL timeout_cycles: got %0d exp 5", cycles5); end
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (start5 !== 1'b1 || cycles5 !== '0 || timed_out5 !== 1'b0) begin
      errors++; $display("FAIL timeout_rego: start %b cycles %0d to %b exp 1 0 0", start5, cycles5, timed_out5);
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) tick();
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    checks++; if (finished5 !== 1'b1 || timed_out5 !== 1'b0 || cycles5 !== 16'd5) begin
      errors++; $display("FAIL done_beats_timeout: fin %b to %b cycles %0d exp 1 0 5",
                         finished5, timed_out5, cycles5);
    end
  endtask

  task automatic test_halt();
    do_reset();
    start_run();
    opcode = 4'h0; fcode = 1'b0;
    tick();
    tick();
    opcode = 4'hF; fcode = 1'b1;
    push_exp("halt_cycle_ctrl", 4'hF, 1'b1, 1'b1);
    #1;
    begin
      exp_t e = sb.pop_front();
      checks++; if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s: got %h exp %h", e.name, ctrl, e.ctrl); end
    end
    tick();
    checks++; if (finished !== 1'b1 || busy !== 1'b0 || cycles !== 16'd3) begin
      errors++; $display("FAIL halt: fin %b busy %b cycles %0d exp 1 0 3", finished, busy, cycles);
    end
  endtask

  task automatic test_nop();
    do_reset();
    start_run();
    opcode = 4'hF; fcode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp($sformatf("nop_cycle%0d", i), 4'hF, 1'b0, 1'b1);
      #1;
      begin
        exp_t e = sb.pop_front();
        checks++; if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s: got %h exp %h", e.name, ctrl, e.ctrl); end
      end
      tick();
    end
    checks++; if (busy !== 1'b1 || finished !== 1'b0 || cycles !== 16'd3) begin
      errors++; $display("FAIL nop_stays_run: busy %b fin %b cycles %0d exp 1 0 3", busy, finished, cycles);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_run();
    opcode = 4'h8; fcode = 1'b0;
    push_exp("pre_reset_ld", 4'h8, 1'b0, 1'b1);
    #1;
    begin
      exp_t e = sb.pop_front();
      checks++; if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s: got %h exp %h", e.name, ctrl, e.ctrl); end
    end
    reset = 1'b1;
    #1;
    checks++; if (start !== 1'b1 || ctrl !== '0) begin
      errors++; $display("FAIL async_reset: start %b ctrl %h exp 1 0", start, ctrl);
    end
    checks++; if (busy !== 1'b0 || cycles !== '0) begin
      errors++; $display("FAIL async_reset_state: busy %b cycles %0d exp 0 0", busy, cycles);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (start !== 1'b1 || busy !== 1'b0 || ctrl !== '0) begin
      errors++; $display("FAIL post_reset_idle: start %b busy %b ctrl %h exp 1 0 0", start, busy, ctrl);
    end
  endtask

  initial begin
    test_reset();
    test_start_sequence();
    test_decode();
    test_run_to_done();
    test_timeout();
    test_halt();
    test_nop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Top-level run controller for the single-cycle 8-bit datapath.
- Holds the datapath in init, releases it on GO, and decodes each fetched opcode/fcode into the datapath CTRL_* strobes.
- Counts executed cycles, detects completion (datapath DONE or HALT) and enforces a watchdog timeout.
- Sits between the testbench/top-level handshake and the datapath.

Parameters:
- INIT_CYCLES, 2, number of cycles START is held high after GO before RUN begins (≥1).
- CNT_W, 16, width of the cycle counter.
- MAX_CYCLES, 16'hFFFF, RUN-cycle limit before the TIMEOUT state is entered (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- GO  in  1  run request, level-sampled each cycle.
- opcode  in  4  instruction [8:5] from the datapath.
- fcode  in  1  instruction [0] from the datapath.
- DP_DONE  in  1  datapath DONE (fetch reached end of program).
- START  out  1  datapath init/reset.
- CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en, CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem  out  1 each  datapath strobes.
- CTRL_alu_op  out  3  ALU operation.
- BUSY  out  1  high in INIT and RUN.
- FINISHED  out  1  high in DONE_ST.
- TIMED_OUT  out  1  high in TIMEOUT.
- CYCLES  out  CNT_W  RUN cycles executed in the current or last run.

Behaviour:
- Reset (asynchronous, immediate, also mid-run): state = IDLE, START = 1, all CTRL_* = 0, BUSY = FINISHED = TIMED_OUT = 0, CYCLES = 0, init counter = 0.
- States and transitions:
  - IDLE: START = 1. When GO = 1, go to INIT and clear CYCLES.
  - INIT: START = 1 for exactly INIT_CYCLES cycles (init counter runs 0..INIT_CYCLES-1), then RUN.
  - RUN: START = 0 and the decoder drives CTRL_* combinationally from opcode/fcode in the same cycle (zero latency; the datapath is single-cycle). CYCLES increments every RUN cycle and saturates at all-ones.
  - RUN exits, checked in priority order:
    1. DP_DONE = 1 → DONE_ST.
    2. HALT (opcode 4'hF, fcode 1) → DONE_ST. The HALT cycle itself drives all CTRL_* = 0 and is counted.
    3. CYCLES == MAX_CYCLES-1 with no completion → TIMEOUT. DONE has priority if both occur in the same cycle.
  - DONE_ST / TIMEOUT: START = 0 (datapath state preserved for inspection), CTRL_* = 0, CYCLES frozen. GO = 1 → INIT and clear CYCLES.
- GO is ignored in INIT and RUN.
- All CTRL_* are forced to 0 outside RUN regardless of opcode.
- Decode (RUN only; unlisted strobes = 0):
  - 0 ADD: alu_op ADD, reg_write_en.
  - 1 SUB: alu_op SUB, reg_write_en.
  - 2 AND, 3 OR, 4 XOR: matching alu_op, reg_write_en.
  - 5 SHL / 6 SHR: alu_op SHL / SHR, reg_write_en, alu_sc_in = fcode.
  - 7 ADDI: alu_op ADD, alu_src, reg_write_en.
  - 8 LD: read_mem, mem_to_reg, reg_write_en.
  - 9 ST: write_mem.
  - A BRZ: branch_rel_z, alu_op SUB.
  - B BRNZ: branch_rel_nz, alu_op SUB.
  - C JMP: branch_abs.
  - D JR: branch_abs, lut_in.
  - E SETPC: reg_sel, reg_write_en.
  - F: fcode 0 = NOP, fcode 1 = HALT.
- ALU op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SHL 5, SHR 6, PASS 7.
- Status outputs are registered state decodes: no glitches, and they change one cycle after the transition condition.

Decomposition:
- Shared package `definitions` holds:
  - opcode_t enum (4-bit values above)
  - alu_op_t enum (3-bit)
  - HALT_FCODE constant
  - seq_state_t enum {IDLE, INIT, RUN, DONE_ST, TIMEOUT}
- Sub-module `ctrl_decode` is purely combinational: opcode + fcode + enable → all CTRL_* outputs. The run_sequencer instantiates it with enable = (state == RUN).

Test Plan:
- Reset then GO = 1 for 1 cycle → START high for exactly 2 cycles after GO, then low; BUSY = 1 through INIT/RUN; CTRL_* = 0 during INIT.
- RUN with opcode 7, fcode x → alu_src = 1, reg_write_en = 1, alu_op = 0 in the same cycle. Opcode 8 → read_mem = mem_to_reg = reg_write_en = 1. Opcode D → branch_abs = lut_in = 1.
- 10 RUN cycles of ADD then DP_DONE = 1 → DONE_ST next cycle, FINISHED = 1, CYCLES = 11, CTRL_* = 0. Re-assert GO → CYCLES = 0 and START = 1.
- MAX_CYCLES = 5 with NOP stream → TIMEOUT after CYCLES = 4 → TIMED_OUT = 1. Repeat with DP_DONE on that same cycle → DONE_ST, not TIMEOUT.
- opcode F, fcode 1 at 3rd RUN cycle → DONE_ST, CYCLES = 3, no strobes during the HALT cycle. Opcode F, fcode 0 → stays in RUN.
- Assert reset in the middle of RUN, between clock edges → START = 1 and all CTRL_* = 0 immediately, without waiting for a clock edge; state = IDLE.
